// File: rtl/fetch_stage.sv
// Instruction fetch stage: holds the PC, reads instruction memory over a req/ready handshake
// and presents one instruction with its PC to decode; redirect flushes, misaligned target faults.
module fetch_stage #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clock,
  input  logic             clear_n,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ready,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             stall,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic [WIDTH-1:0] inst,
  output logic [WIDTH-1:0] inst_pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             inst_valid,
  output logic             fetch_fault,
  output logic [WIDTH-1:0] fetch_count
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] FOUR = WIDTH'(4);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] inst_q, inst_d;
  logic [WIDTH-1:0] inst_pc_q, inst_pc_d;
  logic             inst_valid_q, inst_valid_d;
  logic             fault_q, fault_d;
  logic [WIDTH-1:0] count_q, count_d;

  logic slot_free;
  logic xfer;
  logic target_aligned;

  // The slot is reusable when empty or when decode takes the held instruction this cycle.
  assign slot_free      = ~inst_valid_q | ~stall;
  assign imem_req       = clear_n & (state_q == FETCH) & ~redirect & slot_free;
  assign xfer           = imem_req & imem_ready;
  assign target_aligned = (redirect_pc[1:0] == 2'b00);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    fault_d      = fault_q;
    count_d      = count_q;
    case (state_q)
      BOOT: state_d = FETCH;
      FETCH, FAULT: begin
        if (redirect) begin
          inst_valid_d = 1'b0;
          if (target_aligned) begin
            pc_d    = redirect_pc;
            fault_d = 1'b0;
            state_d = FETCH;
          end else begin
            fault_d = 1'b1;
            state_d = FAULT;
          end
        end else if (state_q == FETCH) begin
          if (xfer) begin
            inst_d       = imem_rdata;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            pc_d         = pc_q + FOUR;
            count_d      = count_q + ONE;
          end else if (inst_valid_q && !stall) begin
            inst_valid_d = 1'b0;
          end
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      fault_q      <= fault_d;
      count_q      <= count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign inst        = inst_q;
  assign inst_pc     = inst_pc_q;
  assign pc_plus4    = inst_pc_q + FOUR;
  assign inst_valid  = inst_valid_q;
  assign fetch_fault = fault_q;
  assign fetch_count = count_q;

endmodule
